payload_char_decoder: RTL and testbench
=======================================

# payload_char_decoder

Upstream byte-to-character-class stage feeding the payload engine array. Accepts the payload byte stream with a valid/ready handshake and looks each byte up in a software-loaded 256-entry class table. It drives the one-hot-per-class `char_class` lines, the `en` strobe and the `sod` clear pulse shared by all `engine_*` instances. It also emits an `eod` strobe so the downstream match collector knows when to sample engine outputs.

## Interface
- `NUM_CLASSES`, 40 — width of the class vector; bit k drives every engine's `in_k`.
- `clk` input 1 — single clock for all logic.
- `rst` input 1 — asynchronous, active-high reset.
- `s_data` input 8 — payload byte.
- `s_valid` input 1 — byte valid.
- `s_last` input 1 — byte is the last of the packet.
- `s_ready` output 1 — decoder accepts the byte this cycle.
- `cfg_we` input 1 — class-table write strobe.
- `cfg_addr` input 8 — table index (byte value).
- `cfg_data` input NUM_CLASSES — class membership for that byte value.
- `cfg_err` output 1 — sticky flag: a write was attempted outside IDLE.
- `char_class` output NUM_CLASSES — class bits of the current byte; valid when `en`=1.
- `en` output 1 — one-cycle strobe per decoded byte (engine CE).
- `sod` output 1 — engine clear, one cycle per packet.
- `eod` output 1 — one-cycle pulse after the last byte of a packet.

## Operation
- Class table: 256 x NUM_CLASSES registers/LUTRAM, written on `cfg_we`. Contents are not reset.
- FSM states:
  - IDLE: `s_ready`=1. Accepting a byte latches it into the hold register and moves to SOD.
  - SOD: `s_ready`=0, `sod`=1, `en`=0. Moves to STREAM unconditionally.
  - STREAM: `s_ready`=1. Each accepted byte is looked up and presented.
    - Accepting a byte with `s_last`=1 returns to IDLE.
    - If the first byte (the one held in SOD) had `s_last`=1, it is presented and the FSM returns to IDLE without accepting more.
- Decode: `char_class` = table[byte] registered, `en`=1 in the same cycle. When `en`=0, `char_class` holds its last value.
- `eod` is asserted the cycle after the `en` of the last byte.
- Packets never overlap. A new first byte is accepted only in IDLE, so `sod` always precedes that packet's first `en` by exactly one cycle.
- `sod` and `en` are never asserted in the same cycle. The engines' CLR would otherwise override CE.
- `cfg_we` is honoured only in IDLE with no pending presentation. In any other cycle the write is dropped and `cfg_err` is set; only `rst` clears it.
- A table write and a byte accept in the same IDLE cycle: the write lands first, and the lookup of the held byte happens later, in STREAM.

## Timing
- Reset values:
  - `sod`=1 (asynchronously set, so engines are cleared during reset).
  - `en`=0, `eod`=0, `char_class`=0, `cfg_err`=0, `s_ready`=0, FSM=IDLE.
- `sod` falls at the first rising edge after `rst` deasserts. `s_ready` rises on that same edge.
- First byte accepted at edge t: `sod`=1 in cycle t+1, `en`=1 with its class in cycle t+2.
- Following bytes accepted at edge t: `en`=1 in cycle t+1. Throughput is one byte/cycle after one bubble per packet.
- Last byte's `en` in cycle n: `eod`=1 in cycle n+1. A new packet's `sod` can occur no earlier than n+1, and may coincide with `eod`.
- `s_valid` low in STREAM: `en`=0 for that cycle. Engine state is held, not cleared.
- `rst` mid-packet: all outputs return to their reset values immediately and the packet is discarded; `eod` is not generated.

## Configuration
- `PAYLOAD_DEC_CASE_FOLD_EN` defined: bytes 0x41–0x5A are mapped to 0x61–0x7A before lookup. Uppercase and lowercase then share one table entry, which serves `/i` rules.
- `PAYLOAD_DEC_CASE_FOLD_EN` not defined: raw byte indexes the table. The table is case-sensitive and software must load both cases.

## Test plan
- Reset release: `rst` 1->0 -> `sod`=1 until the first edge, then 0. `s_ready`=1, `en`=0.
- Table load plus 3-byte packet "Ab." (last on '.'), with table[0x41]=bit6, [0x62]=bit16, [0x2E]=bit35, folding off:
  - `sod` in cycle t+1.
  - `en` with bits 6, 16, 35 in t+2, t+3, t+4.
  - `eod` in t+5.
- Single-byte packet (`s_last` on first byte) -> `sod` at t+1, `en` at t+2, `eod` at t+3, FSM back in IDLE.
- `s_valid` gap of 2 cycles mid-packet -> `en`=0 for 2 cycles, no `sod`, next byte decoded correctly.
- `cfg_we` during STREAM -> table unchanged (read back via decode of that byte), `cfg_err`=1 until `rst`.
- Folding on: byte 0x47 with table[0x67]=bit3 -> `char_class`[3]=1. Folding off -> table[0x47] is used.

Source files
------------

// File: rtl/payload_char_decoder_if.sv
// Payload byte stream, class-table config and engine-facing strobes for payload_char_decoder.
// master = byte/config source side, slave = decoder side.
interface payload_char_decoder_if #(
   parameter int NUM_CLASSES = 40
);
   logic [7:0]             s_data;
   logic                   s_valid;
   logic                   s_last;
   logic                   s_ready;
   logic                   cfg_we;
   logic [7:0]             cfg_addr;
   logic [NUM_CLASSES-1:0] cfg_data;
   logic                   cfg_err;
   logic [NUM_CLASSES-1:0] char_class;
   logic                   en;
   logic                   sod;
   logic                   eod;

   modport master (
      output s_data, s_valid, s_last, cfg_we, cfg_addr, cfg_data,
      input  s_ready, cfg_err, char_class, en, sod, eod
   );

   modport slave (
      input  s_data, s_valid, s_last, cfg_we, cfg_addr, cfg_data,
      output s_ready, cfg_err, char_class, en, sod, eod
   );
endinterface

// File: rtl/payload_char_decoder.sv
// Byte-to-character-class decoder driving the engine array (char_class/en/sod/eod).
// Optional PAYLOAD_DEC_CASE_FOLD_EN folds 'A'-'Z' onto 'a'-'z' before table lookup.
module payload_char_decoder #(
   parameter int NUM_CLASSES = 40
) (
   input logic                  clk,
   input logic                  rst,
   payload_char_decoder_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SOD, STREAM} state_t;

   state_t                 state, state_nxt;
   logic                   alive;
   logic [7:0]             hold_data;
   logic                   hold_last;
   logic [NUM_CLASSES-1:0] class_tbl [256];
   logic [NUM_CLASSES-1:0] class_q;
   logic                   en_q;
   logic                   pres_last_q;
   logic                   eod_q;
   logic                   cfg_err_q;

   logic                   rdy;
   logic                   sod_c;
   logic                   hold_load;
   logic                   fire;
   logic                   fire_last;
   logic [7:0]             fire_byte;
   logic [7:0]             fire_idx;
   logic                   cfg_ok;

   function automatic logic [7:0] fold_byte(input logic [7:0] b);
`ifdef PAYLOAD_DEC_CASE_FOLD_EN
      fold_byte = (b >= 8'h41 && b <= 8'h5A) ? (b | 8'h20) : b;
`else
      fold_byte = b;
`endif
   endfunction

   // alive is low only between reset release and the first edge, which keeps
   // sod high and s_ready low for that window.
   always_comb begin
      state_nxt = state;
      rdy       = 1'b0;
      sod_c     = !alive;
      hold_load = 1'b0;
      fire      = 1'b0;
      fire_byte = hold_data;
      fire_last = hold_last;
      cfg_ok    = 1'b0;
      case (state)
         IDLE: begin
            rdy    = alive;
            cfg_ok = !en_q;
            if (bus.s_valid && alive) begin
               hold_load = 1'b1;
               state_nxt = SOD;
            end
         end
         SOD: begin
            sod_c     = 1'b1;
            fire      = 1'b1;
            state_nxt = STREAM;
         end
         STREAM: begin
            // A single-byte packet was already presented out of SOD.
            if (hold_last) begin
               state_nxt = IDLE;
            end else begin
               rdy = 1'b1;
               if (bus.s_valid) begin
                  fire      = 1'b1;
                  fire_byte = bus.s_data;
                  fire_last = bus.s_last;
                  if (bus.s_last) begin
                     state_nxt = IDLE;
                  end
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign fire_idx = fold_byte(fire_byte);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         alive       <= 1'b0;
         hold_data   <= '0;
         hold_last   <= 1'b0;
         class_q     <= '0;
         en_q        <= 1'b0;
         pres_last_q <= 1'b0;
         eod_q       <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         alive <= 1'b1;
         if (hold_load) begin
            hold_data <= bus.s_data;
            hold_last <= bus.s_last;
         end
         en_q <= fire;
         if (fire) begin
            class_q     <= class_tbl[fire_idx];
            pres_last_q <= fire_last;
         end
         eod_q <= en_q && pres_last_q;
         if (bus.cfg_we && !cfg_ok) begin
            cfg_err_q <= 1'b1;
         end
      end
   end

   // Table contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (bus.cfg_we && cfg_ok) begin
         class_tbl[bus.cfg_addr] <= bus.cfg_data;
      end
   end

   assign bus.s_ready    = rdy;
   assign bus.sod        = sod_c;
   assign bus.en         = en_q;
   assign bus.eod        = eod_q;
   assign bus.char_class = class_q;
   assign bus.cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_payload_char_decoder.sv
// Self-checking bench for payload_char_decoder: cycle vector tables, directed
// corner sequences and randomized packets against a queue-based reference model.
module tb_payload_char_decoder;

   localparam int NC = 40;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   payload_char_decoder_if #(.NUM_CLASSES(NC)) ifc ();

   payload_char_decoder #(.NUM_CLASSES(NC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   typedef struct {
      logic          v;
      logic [7:0]    d;
      logic          l;
      logic          e_sod;
      logic          e_en;
      logic          e_eod;
      logic          e_rdy;
      logic [NC-1:0] e_cls;
      logic          chk_cls;
   } vec_t;

   typedef struct {
      logic [NC-1:0] cls;
      logic          last;
   } exp_t;

   int            checks = 0;
   int            errors = 0;
   logic [NC-1:0] shadow [256];
   vec_t          vecs [$];
   exp_t          expq [$];
   logic          mon_on = 1'b0;
   logic          prev_sod = 1'b0;
   logic          eod_due = 1'b0;

   localparam logic [NC-1:0] C_A   = NC'(1) << 6;
   localparam logic [NC-1:0] C_B   = NC'(1) << 16;
   localparam logic [NC-1:0] C_DOT = NC'(1) << 35;
   localparam logic [NC-1:0] C_30  = NC'(1);
   localparam logic [NC-1:0] C_31  = NC'(1) << 20;
   localparam logic [NC-1:0] C_32  = NC'(1) << 39;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] model_idx(input logic [7:0] b);
`ifdef PAYLOAD_DEC_CASE_FOLD_EN
      return (b >= 8'h41 && b <= 8'h5A) ? b + 8'h20 : b;
`else
      return b;
`endif
   endfunction

   function automatic vec_t mk(input logic v, input logic [7:0] d, input logic l,
                               input logic s, input logic e, input logic o, input logic r,
                               input logic [NC-1:0] c, input logic cc);
      vec_t x;
      x.v = v; x.d = d; x.l = l; x.e_sod = s; x.e_en = e; x.e_eod = o; x.e_rdy = r;
      x.e_cls = c; x.chk_cls = cc;
      return x;
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic write_cfg(input logic [7:0] a, input logic [NC-1:0] d);
      ifc.cfg_we   = 1'b1;
      ifc.cfg_addr = a;
      ifc.cfg_data = d;
      cycle();
      ifc.cfg_we   = 1'b0;
      shadow[a]    = d;
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic l);
      ifc.s_valid = v;
      ifc.s_data  = d;
      ifc.s_last  = l;
   endtask

   // Stream-level reference: presentations in acceptance order, eod right after a last byte.
   always @(negedge clk) begin
      if (mon_on) begin
         check("sod_en_exclusive", 64'(ifc.sod & ifc.en), 64'(0));
         if (prev_sod) check("en_after_sod", 64'(ifc.en), 64'(1));
         check("eod_timing", 64'(ifc.eod), 64'(eod_due));
         eod_due = 1'b0;
         if (ifc.en) begin
            check("en_has_expected", 64'(expq.size() != 0), 64'(1));
            if (expq.size() != 0) begin
               exp_t e;
               e = expq.pop_front();
               check("rand_class", 64'(ifc.char_class), 64'(e.cls));
               eod_due = e.last;
            end
         end
         prev_sod = ifc.sod;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic [63:0] r64;
      logic [7:0]  d;
      logic [NC-1:0] old34, old35;
      int len, wait_cnt;
      logic acc;

      drive(1'b0, 8'h00, 1'b0);
      ifc.cfg_we = 1'b0; ifc.cfg_addr = '0; ifc.cfg_data = '0;

      // Reset release
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("rst_sod", 64'(ifc.sod), 64'(1));
      check("rst_ready", 64'(ifc.s_ready), 64'(0));
      check("rst_en", 64'(ifc.en), 64'(0));
      check("rst_eod", 64'(ifc.eod), 64'(0));
      check("rst_class", 64'(ifc.char_class), 64'(0));
      check("rst_cfg_err", 64'(ifc.cfg_err), 64'(0));
      cycle();
      check("post_rst_sod", 64'(ifc.sod), 64'(0));
      check("post_rst_ready", 64'(ifc.s_ready), 64'(1));
      check("post_rst_en", 64'(ifc.en), 64'(0));

      // Full table load, then the constants used by the vector tables
      for (int i = 0; i < 256; i++) begin
         r64 = {$urandom(), $urandom()};
         write_cfg(8'(i), r64[NC-1:0]);
      end
      write_cfg(8'h41, C_A);
      write_cfg(8'h61, C_A);
      write_cfg(8'h62, C_B);
      write_cfg(8'h2E, C_DOT);
      write_cfg(8'h30, C_30);
      write_cfg(8'h31, C_31);
      write_cfg(8'h32, C_32);
      check("cfg_err_idle_writes", 64'(ifc.cfg_err), 64'(0));

      // "Ab." packet
      vecs.push_back(mk(1, 8'h41, 0, 1, 0, 0, 0, '0,    0));
      vecs.push_back(mk(1, 8'h62, 0, 0, 1, 0, 1, C_A,   1));
      vecs.push_back(mk(1, 8'h62, 0, 0, 1, 0, 1, C_B,   1));
      vecs.push_back(mk(1, 8'h2E, 1, 0, 1, 0, 1, C_DOT, 1));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 1, C_DOT, 1));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, C_DOT, 1));
      // Single-byte packet; the byte offered during the presentation cycle is not taken
      vecs.push_back(mk(1, 8'h30, 1, 1, 0, 0, 0, '0,    0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, C_30,  1));
      vecs.push_back(mk(1, 8'h31, 0, 0, 0, 1, 1, C_30,  1));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, C_30,  1));
      // Two-cycle valid gap mid-packet
      vecs.push_back(mk(1, 8'h31, 0, 1, 0, 0, 0, '0,    0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 1, C_31,  1));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, C_31,  1));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, C_31,  1));
      vecs.push_back(mk(1, 8'h32, 1, 0, 1, 0, 1, C_32,  1));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 1, C_32,  1));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, C_32,  1));

      foreach (vecs[i]) begin
         drive(vecs[i].v, vecs[i].d, vecs[i].l);
         cycle();
         check($sformatf("vec%0d_sod", i), 64'(ifc.sod), 64'(vecs[i].e_sod));
         check($sformatf("vec%0d_en", i), 64'(ifc.en), 64'(vecs[i].e_en));
         check($sformatf("vec%0d_eod", i), 64'(ifc.eod), 64'(vecs[i].e_eod));
         check($sformatf("vec%0d_ready", i), 64'(ifc.s_ready), 64'(vecs[i].e_rdy));
         if (vecs[i].chk_cls) check($sformatf("vec%0d_class", i), 64'(ifc.char_class), 64'(vecs[i].e_cls));
      end

      // Table write and first-byte accept in the same IDLE cycle: lookup sees the new entry
      ifc.cfg_we = 1'b1; ifc.cfg_addr = 8'h36; ifc.cfg_data = ~shadow[8'h36];
      drive(1'b1, 8'h36, 1'b1);
      shadow[8'h36] = ~shadow[8'h36];
      cycle();
      ifc.cfg_we = 1'b0;
      drive(1'b0, 8'h00, 1'b0);
      check("wr_acc_sod", 64'(ifc.sod), 64'(1));
      cycle();
      check("wr_acc_en", 64'(ifc.en), 64'(1));
      check("wr_acc_class", 64'(ifc.char_class), 64'(shadow[8'h36]));
      cycle();
      check("wr_acc_eod", 64'(ifc.eod), 64'(1));
      check("wr_acc_cfg_err", 64'(ifc.cfg_err), 64'(0));

      // Writes during SOD and STREAM are dropped and set the sticky error
      old34 = shadow[8'h34];
      old35 = shadow[8'h35];
      drive(1'b1, 8'h33, 1'b0);
      cycle();
      check("drop_sod_phase", 64'(ifc.sod), 64'(1));
      check("drop_err_clear", 64'(ifc.cfg_err), 64'(0));
      ifc.cfg_we = 1'b1; ifc.cfg_addr = 8'h35; ifc.cfg_data = ~old35;
      drive(1'b0, 8'h00, 1'b0);
      cycle();
      check("drop_sod_err", 64'(ifc.cfg_err), 64'(1));
      check("drop_first_class", 64'(ifc.char_class), 64'(shadow[8'h33]));
      ifc.cfg_addr = 8'h34; ifc.cfg_data = ~old34;
      cycle();
      ifc.cfg_we = 1'b0;
      drive(1'b1, 8'h34, 1'b0);
      cycle();
      check("drop_stream_class", 64'(ifc.char_class), 64'(old34));
      drive(1'b1, 8'h35, 1'b1);
      cycle();
      check("drop_sod_class", 64'(ifc.char_class), 64'(old35));
      drive(1'b0, 8'h00, 1'b0);
      cycle();
      check("drop_eod", 64'(ifc.eod), 64'(1));
      repeat (3) cycle();
      check("cfg_err_sticky", 64'(ifc.cfg_err), 64'(1));

      // Case folding
      r64 = {$urandom(), $urandom()};
      shadow[8'h47] = '0;
      ifc.cfg_we = 1'b1; ifc.cfg_addr = 8'h47; ifc.cfg_data = r64[NC-1:0] & ~(NC'(1) << 3);
      cycle();
      ifc.cfg_we = 1'b0;
      check("cfg_err_still_set", 64'(ifc.cfg_err), 64'(1));
      drive(1'b1, 8'h47, 1'b1);
      cycle();
      drive(1'b0, 8'h00, 1'b0);
      cycle();
      check("fold_en", 64'(ifc.en), 64'(1));
`ifdef PAYLOAD_DEC_CASE_FOLD_EN
      check("fold_class", 64'(ifc.char_class), 64'(shadow[model_idx(8'h47)]));
`else
      check("nofold_class", 64'(ifc.char_class), 64'(r64[NC-1:0] & ~(NC'(1) << 3)));
      shadow[8'h47] = r64[NC-1:0] & ~(NC'(1) << 3);
`endif
      repeat (2) cycle();
      // Table writes above were issued while cfg_err was already set; refresh 0x47 and 0x67 cleanly later.

      // Reset mid-packet
      drive(1'b1, 8'h30, 1'b0);
      cycle();
      drive(1'b0, 8'h00, 1'b0);
      cycle();
      check("mid_en_before_rst", 64'(ifc.en), 64'(1));
      rst = 1'b1;
      #1;
      check("mid_rst_sod", 64'(ifc.sod), 64'(1));
      check("mid_rst_en", 64'(ifc.en), 64'(0));
      check("mid_rst_ready", 64'(ifc.s_ready), 64'(0));
      check("mid_rst_class", 64'(ifc.char_class), 64'(0));
      check("mid_rst_cfg_err", 64'(ifc.cfg_err), 64'(0));
      cycle();
      rst = 1'b0;
      #1;
      check("mid_rel_sod", 64'(ifc.sod), 64'(1));
      cycle();
      check("mid_rel_sod_low", 64'(ifc.sod), 64'(0));
      check("mid_rel_ready", 64'(ifc.s_ready), 64'(1));
      check("mid_no_eod0", 64'(ifc.eod), 64'(0));
      cycle();
      check("mid_no_eod1", 64'(ifc.eod), 64'(0));

      // Fold-pair entries written with a clean error flag
      write_cfg(8'h67, NC'(1) << 3);
      write_cfg(8'h47, NC'(1) << 7);
      drive(1'b1, 8'h47, 1'b1);
      cycle();
      drive(1'b0, 8'h00, 1'b0);
      cycle();
`ifdef PAYLOAD_DEC_CASE_FOLD_EN
      check("fold_bit3", 64'(ifc.char_class[3]), 64'(1));
`else
      check("nofold_bit7", 64'(ifc.char_class), 64'(NC'(1) << 7));
`endif
      repeat (3) cycle();

      // Randomized packets
      mon_on = 1'b1;
      for (int p = 0; p < 60; p++) begin
         len = $urandom_range(1, 6);
         for (int b = 0; b < len; b++) begin
            if ($urandom_range(0, 3) == 0) begin
               drive(1'b0, 8'h00, 1'b0);
               repeat ($urandom_range(1, 2)) cycle();
            end
            d = 8'($urandom_range(0, 255));
            drive(1'b1, d, b == len - 1);
            acc = 1'b0;
            wait_cnt = 0;
            while (!acc && wait_cnt < 10) begin
               acc = ifc.s_ready;
               cycle();
               wait_cnt++;
            end
            check("accept_timeout", 64'(acc), 64'(1));
            if (acc) begin
               exp_t e;
               e.cls  = shadow[model_idx(d)];
               e.last = (b == len - 1);
               expq.push_back(e);
            end
         end
         drive(1'b0, 8'h00, 1'b0);
         if ($urandom_range(0, 3) == 0) begin
            repeat (4) cycle();
            r64 = {$urandom(), $urandom()};
            write_cfg(8'($urandom_range(0, 255)), r64[NC-1:0]);
         end
      end
      repeat (6) cycle();
      check("rand_drained", 64'(expq.size()), 64'(0));
      check("rand_cfg_err", 64'(ifc.cfg_err), 64'(0));
      mon_on = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
